// File: rtl/pipeline_pkg.sv
// Shared pipeline types: arbiter state/owner encodings and datapath widths.
package pipeline_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified memory port.
interface mem_port_arbiter_if import pipeline_pkg::*; #(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = XLEN
) ();

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    // arbiter side
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_ack, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output busy
    );

    // pipeline + memory side
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_ack, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one memory port; data wins unless fetch
// has waited MAX_DSTREAK consecutive data grants.
//   state    | meaning
//   ARB_IDLE | no transaction, grant on any pending request
//   ARB_BUSY | mem_req held, waiting for mem_ack
//   ARB_DONE | owner's ready pulse, requests ignored
module mem_port_arbiter import pipeline_pkg::*; #(
    parameter int ADDR_W      = XLEN,
    parameter int DATA_W      = XLEN,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int         STRB_N     = DATA_W / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    logic [3:0]          streak_q, streak_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_N-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_d, grant_if;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_d     = 1'b0;
        grant_if    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                grant_d  = bus.d_req && !(bus.if_req && (streak_q == STREAK_MAX));
                grant_if = bus.if_req && !grant_d;
                if (grant_d) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWN_D;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_wstrb;
                    // streak only counts grants that made a fetch wait
                    if (bus.if_req && (streak_q != STREAK_MAX))
                        streak_d = streak_q + 4'd1;
                end else if (grant_if) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWN_IF;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    streak_d    = 4'd0;
                end
            end
            ARB_BUSY: begin
                if (bus.mem_ack) begin
                    state_d = ARB_DONE;
                    if (owner_q == OWN_IF)
                        if_rdata_d = bus.mem_rdata;
                    else if (!mem_we_q)
                        d_rdata_d = bus.mem_rdata;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_req   = (state_q == ARB_BUSY);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = (state_q == ARB_DONE) && (owner_q == OWN_IF);
    assign bus.d_ready   = (state_q == ARB_DONE) && (owner_q == OWN_D);
    assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory on the mem side.
module tb_mem_port_arbiter;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // memory model: acks after mem_wait idle cycles of mem_req
    logic        model_ack = 1'b0;
    logic        inj_ack   = 1'b0;
    int          mem_wait  = 0;
    bit          mem_auto  = 1'b1;
    int          wcnt      = 0;
    logic [31:0] mem_arr [0:63];
    logic [5:0]  idx;

    assign bus.mem_ack = model_ack | inj_ack;

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
        mem_arr[4]    = 32'h00500093;
        mem_arr[5]    = 32'h00A00113;
        mem_arr[16]   = 32'h12345678;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (model_ack) begin
                model_ack = 1'b0;
                wcnt      = 0;
            end else if (mem_auto && bus.mem_req) begin
                if (wcnt >= mem_wait) begin
                    model_ack = 1'b1;
                    idx       = bus.mem_addr[7:2];
                    if (bus.mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_wstrb[b]) mem_arr[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        bus.mem_rdata = 32'hBAD0BAD0;
                    end else begin
                        bus.mem_rdata = mem_arr[idx];
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic wait_ready(input bit is_d, input string tag);
        int n = 0;
        while (!(is_d ? bus.d_ready : bus.if_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, is_d ? bus.d_ready : bus.if_ready, 1'b1);
    endtask

    bit   exp_is_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   g;
    logic prev_req;

    initial begin
        reset       = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;

        // reset to idle
        repeat (2) @(negedge clk);
        chk("rst_mem_req",   bus.mem_req,   0);
        chk("rst_mem_we",    bus.mem_we,    0);
        chk("rst_mem_addr",  bus.mem_addr,  0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_wstrb", bus.mem_wstrb, 0);
        chk("rst_if_rdata",  bus.if_rdata,  0);
        chk("rst_if_ready",  bus.if_ready,  0);
        chk("rst_d_rdata",   bus.d_rdata,   0);
        chk("rst_d_ready",   bus.d_ready,   0);
        chk("rst_busy",      bus.busy,      0);
        reset = 1'b0;

        // single fetch, two wait cycles
        mem_wait = 2;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("fetch_mem_req",  bus.mem_req,  1);
                chk("fetch_mem_addr", bus.mem_addr, 32'h10);
                chk("fetch_mem_we",   bus.mem_we,   0);
            end
            chk($sformatf("fetch_if_ready_c%0d", i), bus.if_ready, (i == 4));
            chk($sformatf("fetch_d_ready_c%0d", i),  bus.d_ready,  0);
            chk($sformatf("fetch_busy_c%0d", i),     bus.busy,     (i <= 4));
            if (i == 4) begin
                chk("fetch_if_rdata", bus.if_rdata, 32'h00500093);
                bus.if_req = 1'b0;
            end
        end

        // simultaneous: data first, fetch on the next IDLE
        mem_wait    = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h20;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_wstrb = 4'hF;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h14;
        @(negedge clk);
        chk("simul_mem_we",    bus.mem_we,    1);
        chk("simul_mem_addr",  bus.mem_addr,  32'h20);
        chk("simul_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("simul_mem_wstrb", bus.mem_wstrb, 4'hF);
        wait_ready(1'b1, "simul_d_ready");
        chk("simul_if_ready_during_d", bus.if_ready, 0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(negedge clk);
        chk("simul_idle_mem_req", bus.mem_req, 0);
        @(negedge clk);
        chk("simul_fetch_mem_req",   bus.mem_req,   1);
        chk("simul_fetch_mem_addr",  bus.mem_addr,  32'h14);
        chk("simul_fetch_mem_we",    bus.mem_we,    0);
        chk("simul_fetch_mem_wdata", bus.mem_wdata, 0);
        wait_ready(1'b0, "simul_if_ready");
        chk("simul_if_rdata", bus.if_rdata, 32'h00A00113);

        // starvation bound with both requests held
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h40;
        bus.if_addr = 32'h10;
        bus.if_req  = 1'b1;
        g        = 0;
        prev_req = bus.mem_req;
        for (int c = 0; c < 300 && g < 10; c++) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                chk($sformatf("streak_grant%0d_is_d", g), bus.mem_addr == 32'h40, exp_is_d[g]);
                g++;
            end
            prev_req = bus.mem_req;
        end
        chk("streak_grant_count", g, 10);
        wait_ready(1'b0, "streak_last_if_ready");
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        chk("streak_d_rdata", bus.d_rdata, 32'h12345678);

        // load after store
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h24;
        bus.d_wdata = 32'h000000FF;
        bus.d_wstrb = 4'hF;
        @(negedge clk);
        wait_ready(1'b1, "ls_store_ready");
        chk("ls_store_keeps_rdata", bus.d_rdata, 32'h12345678);
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("ls_after_store_rdata", bus.d_rdata, 32'h12345678);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_wstrb = 4'h0;
        @(negedge clk);
        wait_ready(1'b1, "ls_load_ready");
        chk("ls_load_rdata", bus.d_rdata, 32'h000000FF);
        bus.d_req = 1'b0;
        @(negedge clk);

        // reset mid-operation, late ack ignored
        mem_auto   = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h28;
        @(negedge clk);
        chk("rmid_busy_before", bus.mem_req, 1);
        reset     = 1'b1;
        bus.d_req = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        inj_ack = 1'b1;
        chk("rmid_mem_req",  bus.mem_req,  0);
        chk("rmid_busy",     bus.busy,     0);
        chk("rmid_mem_addr", bus.mem_addr, 0);
        chk("rmid_d_rdata",  bus.d_rdata,  0);
        @(negedge clk);
        inj_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rmid_d_ready_%0d", i), bus.d_ready, 0);
            chk($sformatf("rmid_idle_%0d", i),    bus.busy,    0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the pipeline's instruction fetch (IF) and its EX-stage load/store path. Each transaction is granted to one requester, driven to memory until acknowledged, and answered with a one-cycle ready pulse. Data accesses have priority, but a bounded-streak rule prevents fetch starvation. `busy` feeds the pipeline stall logic.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `MAX_DSTREAK`, 4, maximum consecutive data grants while a fetch is pending; range 1-15
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, all state is sampled on `clk`
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word, valid while `if_ready`=1
- `if_ready`  out  1  one-cycle completion pulse for fetch
- `d_req`  in  1  data request; held with its fields stable until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  byte enables, stores only
- `d_rdata`  out  DATA_W  load result, valid while `d_ready`=1
- `d_ready`  out  1  one-cycle completion pulse for data
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted request
- `mem_ack`  in  1  memory completion; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - If any request is pending, grant one, latch its fields into the `mem_*` registers, record the owner, and go to BUSY.
  - If no request is pending, stay in IDLE.
- **Grant rule (IDLE only)**
  - Only `d_req`: grant data.
  - Only `if_req`: grant fetch.
  - Both pending: grant fetch if `streak == MAX_DSTREAK`, otherwise grant data.
- **Streak counter**
  - Resets to 0 on every fetch grant.
  - Increments, saturating at `MAX_DSTREAK`, on a data grant while `if_req`=1.
  - Holds on a data grant while `if_req`=0.
- **BUSY**
  - `mem_req`=1.
  - On `mem_ack`: capture `mem_rdata` into the owner's rdata register, go to DONE, and drop `mem_req` next cycle.
  - On a store, `d_rdata` keeps its previous value.
- **DONE**
  - The owner's ready output is 1 for exactly this cycle.
  - All requests are ignored, because the owner's req may still be high.
  - Next state is IDLE unconditionally.
- **Illegal or ignored inputs**
  - `mem_ack` in IDLE or DONE is ignored.
  - Withdrawing a request before grant has no effect.
  - Withdrawing a request after grant is illegal; the transaction completes regardless.
- **Reset**
  - Next state is IDLE, regardless of current state.
  - All outputs go to 0, `streak` goes to 0, and any in-flight transaction is abandoned.
  - A `mem_ack` arriving after reset is ignored.

## Timing
- Reset values: every output is 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `if_rdata`, `if_ready`, `d_rdata`, `d_ready`, `busy`); state is IDLE; `streak` is 0.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Single transaction, with request sampled at edge k:
  - `mem_req`=1 from cycle k+1.
  - If `mem_ack` is sampled at edge k+1+n, ready is high in cycle k+2+n.
  - IDLE is reached at k+3+n.
- Minimum turnaround (n=0) is 3 cycles per transaction.
- Back-to-back: a request held through DONE is eligible for grant in the first IDLE cycle.
- `busy` rises in the cycle after the grant edge and falls in the cycle after DONE.

## Structure
- Shared package `pipeline_pkg` holds:
  - `arb_state_t` with values ARB_IDLE, ARB_BUSY, ARB_DONE
  - `arb_owner_t` with values OWN_IF, OWN_D
  - width constants `XLEN`=32, `STRB_W`=4
- No sub-module: the FSM, streak counter and request registers sit in one file.
- The memory model is owned by the bench, not this block.

## Test plan
- **Reset to idle:** reset for 2 cycles with all inputs at 0 → every output is 0 and `busy`=0.
- **Single fetch:** `if_req`=1, `if_addr`=0x10, memory acks after 2 wait cycles with 0x00500093 → `mem_addr`=0x10, `if_ready` pulses for one cycle in cycle k+4, `if_rdata`=0x00500093, `d_ready` stays 0.
- **Simultaneous requests:** `if_req` and `d_req` both 1 (store to 0x20, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF) → data granted first (`mem_we`=1, `mem_addr`=0x20); fetch granted on the next IDLE.
- **Starvation bound:** `d_req` and `if_req` held continuously, `MAX_DSTREAK`=4 → grant order is D,D,D,D,IF,D,D,D,D,IF.
- **Load after store:** store 0x000000FF to 0x24, then load from 0x24 with the memory returning 0x000000FF → `d_rdata`=0x000000FF; `d_rdata` is unchanged after the store's `d_ready`.
- **Reset mid-operation:** reset asserted in BUSY, with `mem_ack`=1 in the following cycle → `mem_req`=0 the cycle after reset, no ready pulse, state IDLE, late ack ignored.
